micro_p_leds_pio: RTL and testbench

//  Avalon-MM slave output port: the write-side counterpart of the switch input port.

---
 rtl/micro_p_leds_pio.sv | 68 ++++++
 tb/tb_micro_p_leds_pio.sv | 124 ++++++++++++
 2 files changed

// File: rtl/micro_p_leds_pio.sv
// micro_p_leds_pio: Avalon-MM LED output port with atomic set/clear and a hardware blink engine.
module micro_p_leds_pio #(
  parameter int DATA_WIDTH = 8,
  parameter int PERIOD_W = 24,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);
  logic [DATA_WIDTH-1:0] r_data, r_mask, w_wd, w_data_nxt;
  logic [PERIOD_W-1:0]   r_period, r_cnt, w_pw;
  logic                  r_phase, w_we, w_run, w_unused;
  logic [31:0]           w_rd;
  assign w_we     = chipselect & ~write_n;
  assign w_wd     = writedata[DATA_WIDTH-1:0];
  assign w_pw     = writedata[PERIOD_W-1:0];
  assign w_run    = r_period != '0;
  assign w_unused = &{1'b0, writedata};
  assign out_port = r_data ^ (r_mask & {DATA_WIDTH{r_phase}});
  always_comb begin
    w_data_nxt = r_data;
    if (w_we)
      w_data_nxt = address == 3'd0 ? w_wd :
                   address == 3'd4 ? r_data | w_wd :
                   address == 3'd5 ? r_data & ~w_wd : r_data;
  end
  always_comb begin
    w_rd = '0;
    w_rd = address == 3'd0 ? 32'(r_data) :
           address == 3'd1 ? 32'(r_mask) :
           address == 3'd2 ? 32'(r_period) :
           address == 3'd3 ? {30'd0, w_run, r_phase} : 32'd0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data   <= RESET_VALUE;
      r_mask   <= '0;
      readdata <= '0;
    end else begin
      r_data   <= w_data_nxt;
      readdata <= w_rd;
      if (w_we && address == 3'd1) r_mask <= w_wd;
    end
  end
  // A PERIOD write restarts the engine; the reload at zero gives a toggle every PERIOD clocks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_period <= '0;
      r_cnt    <= '0;
      r_phase  <= 1'b0;
    end else if (w_we && address == 3'd2) begin
      r_period <= w_pw;
      r_cnt    <= w_pw == '0 ? '0 : w_pw - PERIOD_W'(1);
      r_phase  <= 1'b0;
    end else if (w_run && r_cnt == '0) begin
      r_cnt    <= r_period - PERIOD_W'(1);
      r_phase  <= ~r_phase;
    end else if (w_run) begin
      r_cnt    <= r_cnt - PERIOD_W'(1);
    end
  end
endmodule

// File: tb/tb_micro_p_leds_pio.sv
// tb_micro_p_leds_pio: directed vector table plus blink/reset sequences for the LED PIO.
module tb_micro_p_leds_pio;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  int n_chk = 0;
  int n_fail = 0;

  localparam logic [7:0] RV = 8'h3C;

  micro_p_leds_pio #(.DATA_WIDTH(8), .PERIOD_W(24), .RESET_VALUE(RV)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  a;
    logic [31:0] d;
    logic [7:0]  eo;
    logic [31:0] er;
  } vec_t;
  vec_t v[13];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic cyc(input logic we, input logic [2:0] a, input logic [31:0] d);
    address = a;
    chipselect = we;
    write_n = ~we;
    writedata = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  function automatic logic ph(input int k);
    return ((k / 4) % 2) == 1;
  endfunction

  initial begin
    v[0]  = '{1'b1, 3'd0, 32'hA5, 8'hA5, 32'h3C};
    v[1]  = '{1'b0, 3'd0, 32'h0,  8'hA5, 32'hA5};
    v[2]  = '{1'b1, 3'd4, 32'h0A, 8'hAF, 32'h0};
    v[3]  = '{1'b1, 3'd5, 32'h81, 8'h2E, 32'h0};
    v[4]  = '{1'b0, 3'd0, 32'h0,  8'h2E, 32'h2E};
    v[5]  = '{1'b1, 3'd1, 32'hF0, 8'h2E, 32'h0};
    v[6]  = '{1'b0, 3'd1, 32'h0,  8'h2E, 32'hF0};
    v[7]  = '{1'b1, 3'd3, 32'hFF, 8'h2E, 32'h0};
    v[8]  = '{1'b1, 3'd6, 32'hFF, 8'h2E, 32'h0};
    v[9]  = '{1'b0, 3'd7, 32'h0,  8'h2E, 32'h0};
    v[10] = '{1'b0, 3'd2, 32'h0,  8'h2E, 32'h0};
    v[11] = '{1'b1, 3'd0, 32'h0,  8'h00, 32'h2E};
    v[12] = '{1'b1, 3'd1, 32'h0F, 8'h00, 32'hF0};

    repeat (3) @(negedge clk);
    chk("reset_out", {24'd0, out_port}, {24'd0, RV});
    chk("reset_rd", readdata, 32'h0);
    reset_n = 1'b1;
    cyc(1'b0, 3'd3, 32'h0);
    chk("status_after_reset", readdata, 32'h0);
    chk("out_after_reset", {24'd0, out_port}, {24'd0, RV});

    for (int i = 0; i < 13; i++) begin
      cyc(v[i].we, v[i].a, v[i].d);
      chk($sformatf("vec%0d_out", i), {24'd0, out_port}, {24'd0, v[i].eo});
      chk($sformatf("vec%0d_rd", i), readdata, v[i].er);
    end

    cyc(1'b1, 3'd2, 32'd4);
    chk("blink_k0_out", {24'd0, out_port}, 32'h0);
    for (int k = 1; k <= 12; k++) begin
      cyc(1'b0, 3'd3, 32'h0);
      chk($sformatf("blink_k%0d_out", k), {24'd0, out_port}, ph(k) ? 32'h0F : 32'h0);
      chk($sformatf("blink_k%0d_status", k), readdata, {30'd0, 1'b1, ph(k - 1)});
    end

    cyc(1'b1, 3'd2, 32'd0);
    chk("stop_out", {24'd0, out_port}, 32'h0);
    chk("stop_rd_period", readdata, 32'd4);
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 3'd3, 32'h0);
      chk($sformatf("stopped%0d_out", k), {24'd0, out_port}, 32'h0);
      chk($sformatf("stopped%0d_status", k), readdata, 32'h0);
    end

    cyc(1'b1, 3'd2, 32'd2);
    cyc(1'b0, 3'd0, 32'h0);
    chk("p2_before_toggle", {24'd0, out_port}, 32'h0);
    cyc(1'b0, 3'd0, 32'h0);
    chk("p2_phase1_out", {24'd0, out_port}, 32'h0F);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_out", {24'd0, out_port}, {24'd0, RV});
    chk("async_reset_rd", readdata, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 3'd3, 32'h0);
      chk($sformatf("post_reset%0d_out", k), {24'd0, out_port}, {24'd0, RV});
      chk($sformatf("post_reset%0d_status", k), readdata, 32'h0);
    end
    cyc(1'b0, 3'd1, 32'h0);
    chk("post_reset_mask", readdata, 32'h0);
    cyc(1'b0, 3'd2, 32'h0);
    chk("post_reset_period", readdata, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
